// File: rtl/ntt_job_scheduler.sv
// Round-robin job scheduler that shares one NTT engine among NUM_REQ requesters (optional watchdog: NTT_SCHED_WDT_EN).
// Latency: accept at T, ntt_start_o at T+1; ntt_done_i at D gives cpl_valid_o at D+1, next accept no earlier than D+2.
// Backpressure: a single job is outstanding; req_ready_o stays low outside IDLE and while rst_i is high.
module ntt_job_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 56,
    parameter int WDT_CYCLES = 65536
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ-1:0]          req_mode_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic [NUM_REQ-1:0]          cpl_valid_o,
    output logic                        cpl_error_o,
    output logic                        ntt_start_o,
    output logic                        ntt_mode_o,
    output logic [ADDR_W-1:0]           ntt_addr_o,
    input  logic                        ntt_done_i,
    output logic                        busy_o,
    output logic [$clog2(NUM_REQ)-1:0]  owner_o
);

    localparam int OW = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_CPL   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [OW-1:0]     last_q, last_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    logic [OW-1:0]     win_idx;
    logic [OW-1:0]     scan_idx;
    logic              win_vld;
    logic              wdt_hit;

`ifdef NTT_SCHED_WDT_EN
    logic [31:0] wdt_q, wdt_d;

    assign wdt_hit = (wdt_q == 32'(WDT_CYCLES - 1));

    // Watchdog count restarts as the job enters WAIT and advances once per WAIT cycle.
    always_comb begin
        wdt_d = wdt_q;
        if (state_q == ST_ISSUE) begin
            wdt_d = '0;
        end else if (state_q == ST_WAIT) begin
            wdt_d = wdt_q + 32'd1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    logic unused_wdt;

    assign wdt_hit    = 1'b0;
    assign unused_wdt = (WDT_CYCLES != 0);
`endif

    // Round-robin pick: first valid requester scanning upward from the one after last_q.
    always_comb begin
        win_idx  = '0;
        win_vld  = 1'b0;
        scan_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = OW'((int'(last_q) + k) % NUM_REQ);
            if (!win_vld && req_valid_i[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    // Only the winner sees ready, and only in IDLE outside reset, so ready implies handshake.
    always_comb begin
        req_ready_o = '0;
        if (!rst_i && (state_q == ST_IDLE) && win_vld) begin
            req_ready_o[win_idx] = 1'b1;
        end
    end

    // FSM next state plus job latching; done outside WAIT is deliberately ignored.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d = ST_ISSUE;
                    owner_d = win_idx;
                    mode_d  = req_mode_i[win_idx];
                    addr_d  = req_addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                err_d   = 1'b0;
            end
            ST_WAIT: begin
                if (ntt_done_i) begin
                    state_d = ST_CPL;
                end else if (wdt_hit) begin
                    state_d = ST_CPL;
                    err_d   = 1'b1;
                end
            end
            ST_CPL: begin
                last_d  = owner_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; the pointer resets to the last index so requester 0 wins first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            last_q  <= OW'(NUM_REQ - 1);
            owner_q <= '0;
            mode_q  <= 1'b0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    // Completion pulse goes only to the owner of the finishing job.
    always_comb begin
        cpl_valid_o = '0;
        if (state_q == ST_CPL) begin
            cpl_valid_o[owner_q] = 1'b1;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign ntt_start_o = (state_q == ST_ISSUE);
    assign ntt_mode_o  = busy_o & mode_q;
    assign ntt_addr_o  = busy_o ? addr_q : '0;
    assign cpl_error_o = (state_q == ST_CPL) & err_q;
    assign owner_o     = owner_q;

endmodule

// File: tb/tb_ntt_job_scheduler.sv
// Bench for ntt_job_scheduler: randomized requesters plus a job-level reference model feeding a scoreboard.
// The model schedules grants/starts/completions by cycle; a negedge monitor pops and compares DUT outputs.
// The engine's done pulse is driven from the model's own timeline, never from DUT outputs.
module tb_ntt_job_scheduler;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 56;
`ifdef NTT_SCHED_WDT_EN
    localparam int WDT = 16;
`else
    localparam int WDT = 65536;
`endif

    bit                          clk = 1'b0;
    logic                        rst;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_mode;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ-1:0]          cpl_valid;
    logic                        cpl_error;
    logic                        ntt_start;
    logic                        ntt_mode;
    logic [ADDR_W-1:0]           ntt_addr;
    logic                        ntt_done;
    logic                        busy;
    logic [$clog2(NUM_REQ)-1:0]  owner;

    ntt_job_scheduler #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .WDT_CYCLES(WDT)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_mode_i(req_mode),
        .req_addr_i(req_addr), .req_ready_o(req_ready), .cpl_valid_o(cpl_valid),
        .cpl_error_o(cpl_error), .ntt_start_o(ntt_start), .ntt_mode_o(ntt_mode),
        .ntt_addr_o(ntt_addr), .ntt_done_i(ntt_done), .busy_o(busy), .owner_o(owner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                 cyc;
        int                 idx;
        logic [NUM_REQ-1:0] vec;
        logic               mode;
        logic [ADDR_W-1:0]  addr;
        logic               err;
    } exp_t;

    exp_t q_grant[$];
    exp_t q_start[$];
    exp_t q_cpl[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: job-level view of the shared engine.
    bit                m_free = 1'b0;
    int                m_last = NUM_REQ - 1;
    int                free_at = 0;
    int                start_cyc = -1;
    int                done_cyc = -1;
    int                cpl_cyc = -1;
    int                late_done_cyc = -1;
    int                rst_zero_cyc = -1;
    int                busy_from = -1;
    int                busy_to = -2;
    int                granted_prev = -1;
    bit                hold   [NUM_REQ];
    bit                h_mode [NUM_REQ];
    bit [ADDR_W-1:0]   h_addr [NUM_REQ];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp_v, cyc);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = hold[i];
            req_mode[i]  = h_mode[i];
            req_addr[i*ADDR_W +: ADDR_W] = h_addr[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of requester behaviour plus the scheduler/engine reference model.
    // rmode: 0 no new requests, 1 random traffic, 2 every idle requester raises a job.
    task automatic model_cycle(input int rmode, input bit allow_rst, input int dly_fix, input bit wdt);
        int   w;
        exp_t e;
        rst      = 1'b0;
        ntt_done = 1'b0;
        if (granted_prev >= 0) begin
            hold[granted_prev] = 1'b0;
            granted_prev = -1;
        end
        if (!m_free && cyc >= free_at) m_free = 1'b1;

        if (allow_rst && !m_free && cyc > start_cyc && cyc < done_cyc && $urandom_range(0, 29) == 0) begin
            rst = 1'b1;
            q_cpl.delete(q_cpl.size() - 1);
            done_cyc     = -1;
            busy_to      = cyc;
            free_at      = cyc + 1;
            m_last       = NUM_REQ - 1;
            rst_zero_cyc = cyc + 1;
            for (int i = 0; i < NUM_REQ; i++) hold[i] = 1'b0;
            drive_reqs();
            return;
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            if (!hold[i]) begin
                if ((rmode == 2) || (rmode == 1 && cyc != rst_zero_cyc && $urandom_range(0, 3) == 0)) begin
                    hold[i]   = 1'b1;
                    h_mode[i] = 1'($urandom);
                    h_addr[i] = ADDR_W'({$urandom, $urandom});
                end
            end else if (rmode == 1 && !m_free && $urandom_range(0, 19) == 0) begin
                hold[i] = 1'b0;
            end
        end
        drive_reqs();

        if (cyc == done_cyc || cyc == late_done_cyc) begin
            ntt_done = 1'b1;
        end else if (rmode == 1 && (m_free || cyc == start_cyc || cyc == cpl_cyc) && $urandom_range(0, 4) == 0) begin
            ntt_done = 1'b1;
        end

        if (m_free && (req_valid != '0)) begin
            w = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (w < 0 && hold[(m_last + k) % NUM_REQ]) w = (m_last + k) % NUM_REQ;
            end
            m_free       = 1'b0;
            m_last       = w;
            granted_prev = w;
            start_cyc    = cyc + 1;
            busy_from    = cyc + 1;
            e.idx  = w;
            e.vec  = NUM_REQ'(1) << w;
            e.mode = h_mode[w];
            e.addr = h_addr[w];
            e.err  = 1'b0;
            e.cyc  = cyc;
            q_grant.push_back(e);
            e.cyc  = start_cyc;
            q_start.push_back(e);
            if (wdt) begin
`ifdef NTT_SCHED_WDT_EN
                done_cyc      = -1;
                cpl_cyc       = start_cyc + WDT + 1;
                late_done_cyc = cpl_cyc + 3;
                e.err         = 1'b1;
`else
                done_cyc = start_cyc + 1000;
                cpl_cyc  = done_cyc + 1;
`endif
            end else begin
                done_cyc = start_cyc + ((dly_fix > 0) ? dly_fix : int'($urandom_range(1, 8)));
                cpl_cyc  = done_cyc + 1;
            end
            free_at = cpl_cyc + 1;
            busy_to = cpl_cyc;
            e.cyc   = cpl_cyc;
            q_cpl.push_back(e);
        end
    endtask

    task automatic drain();
        bit any;
        for (int n = 0; n < 2000; n++) begin
            any = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) any |= hold[i];
            if (m_free && !any) break;
            model_cycle(0, 1'b0, 0, 1'b0);
            tick();
        end
    endtask

    // Monitor: per-cycle busy/reset checks, and scoreboard pops whenever the DUT presents an event.
    always @(negedge clk) begin : mon
        exp_t e;
        chk("busy", 64'(busy), 64'((cyc >= busy_from) && (cyc <= busy_to)));
        if (rst) chk("ready_in_rst", 64'(req_ready), 64'd0);
        if (cyc == rst_zero_cyc) begin
            chk("rst_ready", 64'(req_ready), 64'd0);
            chk("rst_cpl", 64'(cpl_valid), 64'd0);
            chk("rst_start", 64'(ntt_start), 64'd0);
            chk("rst_mode", 64'(ntt_mode), 64'd0);
            chk("rst_addr", 64'(ntt_addr), 64'd0);
            chk("rst_owner", 64'(owner), 64'd0);
        end
        if (req_ready != '0) begin
            if (q_grant.size() == 0) begin
                chk("unexpected_grant", 64'(req_ready), 64'd0);
            end else begin
                e = q_grant.pop_front();
                chk("grant_cycle", 64'(cyc), 64'(e.cyc));
                chk("grant_vec", 64'(req_ready), 64'(e.vec));
            end
        end
        if (ntt_start) begin
            if (q_start.size() == 0) begin
                chk("unexpected_start", 64'(ntt_start), 64'd0);
            end else begin
                e = q_start.pop_front();
                chk("start_cycle", 64'(cyc), 64'(e.cyc));
                chk("start_mode", 64'(ntt_mode), 64'(e.mode));
                chk("start_addr", 64'(ntt_addr), 64'(e.addr));
            end
        end
        if (cpl_valid != '0) begin
            if (q_cpl.size() == 0) begin
                chk("unexpected_cpl", 64'(cpl_valid), 64'd0);
            end else begin
                e = q_cpl.pop_front();
                chk("cpl_cycle", 64'(cyc), 64'(e.cyc));
                chk("cpl_vec", 64'(cpl_valid), 64'(e.vec));
                chk("cpl_error", 64'(cpl_error), 64'(e.err));
                chk("cpl_owner", 64'(owner), 64'(e.idx));
                chk("cpl_addr_held", 64'(ntt_addr), 64'(e.addr));
            end
        end
    end

    initial begin
        // Reset with every requester asserting: ready must stay low throughout.
        rst      = 1'b1;
        ntt_done = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hold[i]   = 1'b1;
            h_mode[i] = 1'($urandom);
            h_addr[i] = ADDR_W'({$urandom, $urandom});
        end
        drive_reqs();
        repeat (3) @(posedge clk);
        #1;
        m_free = 1'b1;
        drain();

        // Single job: mode 1, addr 0x1000, done 9 cycles after start.
        hold[0]   = 1'b1;
        h_mode[0] = 1'b1;
        h_addr[0] = ADDR_W'(56'h1000);
        model_cycle(0, 1'b0, 9, 1'b0);
        tick();
        repeat (14) begin
            model_cycle(0, 1'b0, 0, 1'b0);
            tick();
        end

        // Fairness: all requesters held, fixed 5-cycle engine latency.
        repeat (40) begin
            model_cycle(2, 1'b0, 5, 1'b0);
            tick();
        end
        drain();

        // Random traffic with drops, spurious done pulses and resets during WAIT.
        repeat (3000) begin
            model_cycle(1, 1'b1, 0, 1'b0);
            tick();
        end
        drain();

        // Engine never finishes on its own: watchdog abort, or a long WAIT without it.
        hold[2]   = 1'b1;
        h_mode[2] = 1'($urandom);
        h_addr[2] = ADDR_W'({$urandom, $urandom});
        model_cycle(0, 1'b0, 0, 1'b1);
        tick();
        repeat (1100) begin
            model_cycle(0, 1'b0, 0, 1'b0);
            tick();
        end
        drain();
        repeat (5) begin
            model_cycle(0, 1'b0, 0, 1'b0);
            tick();
        end

        chk("leftover_grants", 64'(q_grant.size()), 64'd0);
        chk("leftover_starts", 64'(q_start.size()), 64'd0);
        chk("leftover_cpls", 64'(q_cpl.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
